// File: rtl/muldiv_pkg.sv
// Shared constants and types for the EX-stage RV32M multiply/divide engine.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [1:0] FWD_IDEX = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fwd_operand_mux.sv
// 3:1 forwarding operand select; the unused select value 3 falls back to the ID/EX value.
module fwd_operand_mux
  import muldiv_pkg::*;
(
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] idex_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);

  always_comb begin
    case (sel)
      FWD_MEM: operand = mem_data;
      FWD_WB:  operand = wb_data;
      default: operand = idex_data;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage with internal forwarding muxes.
// Build option MULDIV_FAST_MUL_EN: multiplies finish in one step on a 33x33 signed multiplier.
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic [1:0]      ForwardRS1Src,
  input  logic [1:0]      ForwardRS2Src,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  // Handshake: an instruction is taken on the edge where IDLE sees req_valid && !flush;
  // stall holds the pipeline until DONE, where result_valid pulses once and EX/MEM captures result.

  state_t            state, state_nxt;
  logic [XLEN-1:0]   a_in, b_in;
  logic              accept, take_fast;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs, fast_res;
  logic              div_zero, div_ovf;

  logic [2:0]        op_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   opb_q, hi_q, lo_q, result_q;

  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, hi_nx, lo_nx, calc_res;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_nx, prod_fix;

  fwd_operand_mux u_rs1_mux (
    .sel       (ForwardRS1Src),
    .idex_data (rs1_data),
    .mem_data  (mem_fwd_data),
    .wb_data   (wb_fwd_data),
    .operand   (a_in)
  );

  fwd_operand_mux u_rs2_mux (
    .sel       (ForwardRS2Src),
    .idex_data (rs2_data),
    .mem_data  (mem_fwd_data),
    .wb_data   (wb_fwd_data),
    .operand   (b_in)
  );

  assign accept = (state == IDLE) && req_valid && !flush;

  always_comb begin
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed && a_in[XLEN-1];
    b_neg    = b_signed && b_in[XLEN-1];
    a_abs    = a_neg ? (~a_in + 1'b1) : a_in;
    b_abs    = b_neg ? (~b_in + 1'b1) : b_in;
    div_zero = funct3[2] && (b_in == '0);
    div_ovf  = funct3[2] && !funct3[0] && (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (b_in == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN-1:0] fm_p;
  always_comb begin
    fm_a = {a_signed && a_in[XLEN-1], a_in};
    fm_b = {b_signed && b_in[XLEN-1], b_in};
    fm_p = 64'(fm_a) * 64'(fm_b);
  end
`endif

  // Results that need no iteration are settled at the acceptance edge.
  always_comb begin
    take_fast = 1'b0;
    fast_res  = '0;
    if (funct3[2]) begin
      if (div_zero) begin
        take_fast = 1'b1;
        fast_res  = funct3[1] ? a_in : '1;
      end else if (div_ovf) begin
        take_fast = 1'b1;
        fast_res  = funct3[1] ? '0 : a_in;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      take_fast = 1'b1;
      fast_res  = (funct3 == F3_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    end
`endif
  end

  // One radix-2 step: hi/lo hold the product halves or the remainder/quotient pair.
  always_comb begin
    mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift[XLEN-1:0] - opb_q;
    if (op_q[2]) begin
      hi_nx = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod_nx  = {hi_nx, lo_nx};
    prod_fix = neg_q ? (~prod_nx + 1'b1) : prod_nx;
    case (op_q)
      F3_MUL:           calc_res = prod_fix[XLEN-1:0];
      F3_DIV, F3_DIVU:  calc_res = neg_q ? (~lo_nx + 1'b1) : lo_nx;
      F3_REM, F3_REMU:  calc_res = neg_q ? (~hi_nx + 1'b1) : hi_nx;
      default:          calc_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = take_fast ? DONE : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall        = accept || ((state == CALC) && !flush);
    busy         = (state != IDLE);
    result_valid = (state == DONE) && !flush;
    result       = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= funct3;
      neg_q <= (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
      cnt   <= CNT_W'(XLEN);
      opb_q <= b_abs;
      hi_q  <= '0;
      lo_q  <= a_abs;
      if (take_fast) result_q <= fast_res;
    end else if ((state == CALC) && !flush) begin
      hi_q <= hi_nx;
      lo_q <= lo_nx;
      cnt  <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) result_q <= calc_res;
    end
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine in the EX stage, directly downstream of the forwarding unit.
- Consumes the 2-bit forward selects (0 = ID/EX register value, 1 = EX/MEM result, 2 = MEM/WB result) and muxes operands internally.
- Latches operands, computes over multiple cycles, and holds the pipeline via stall until the result is ready for the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  ID/EX holds a valid M-extension instruction (opcode 0110011, funct7 0000001)
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  input  XLEN  rs1 value from ID/EX register
- rs2_data  input  XLEN  rs2 value from ID/EX register
- mem_fwd_data  input  XLEN  EX/MEM ALU result (select 1)
- wb_fwd_data  input  XLEN  MEM/WB writeback data (select 2)
- ForwardRS1Src  input  2  rs1 operand select
- ForwardRS2Src  input  2  rs2 operand select
- flush  input  1  branch/jump kill of the EX instruction
- stall  output  1  freeze PC, IF/ID, ID/EX; bubble into EX/MEM
- busy  output  1  FSM not IDLE
- result_valid  output  1  one-cycle pulse; result is valid
- result  output  XLEN  rd value for EX/MEM

Behaviour:
- Reset: state IDLE, stall 0, busy 0, result_valid 0, result 0, counter 0, all datapath registers 0.
- Operand mux: select value 3 behaves as 0. The mux is sampled only at the acceptance edge; later forward-path changes are ignored.
- States: IDLE, CALC, DONE.
- IDLE -> CALC when req_valid && !flush. At this edge the unit latches both operands and funct3, takes absolute values for signed ops, records result sign, and loads counter = XLEN.
- IDLE -> DONE directly, with result computed at the acceptance edge, for:
  - divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend.
  - signed overflow (0x80000000 / -1): DIV gives 0x80000000; REM gives 0.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract.
  - Counter decrements each cycle; counter == 1 -> DONE.
- DONE: result_valid = 1 for exactly one cycle; result is held until the next acceptance. Sign correction is applied on entry to DONE. Always DONE -> IDLE.
- Result selection:
  - MUL gives product[31:0]; MULH, MULHSU and MULHU give product[63:32].
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - Remainder takes the dividend's sign.
- stall = (state == IDLE && req_valid && !flush) || state == CALC.
  - Stall is low in DONE, so the pipeline advances and EX/MEM captures result.
  - The ID/EX register is frozen, so req_valid is still high in DONE. The DONE -> IDLE transition does not start a new operation that cycle.
  - The next instruction enters ID/EX at the same edge as DONE -> IDLE, so IDLE accepts it on the following cycle.
- Latency: normal ops take 34 cycles from req_valid rising to the result_valid pulse (1 accept + 32 CALC + 1 DONE). Fast-path ops take 2 cycles.
- flush in CALC or DONE: next state IDLE; result_valid suppressed; stall drops in the same cycle (combinational).
- rst mid-operation: all state returns to reset values at the next edge.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL, MULH, MULHSU and MULHU go IDLE -> DONE using a single-cycle 33x33 signed multiplier, for a 2-cycle latency. Divide is unchanged.
- Undefined: all multiplies use the iterative CALC path (34 cycles). No hardware multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg holds:
  - the funct3 encodings as localparams;
  - the FSM state enum (IDLE, CALC, DONE);
  - forward-select constants FWD_IDEX = 0, FWD_MEM = 1, FWD_WB = 2;
  - XLEN.
- One sub-module, fwd_operand_mux: 3:1 operand select, instantiated twice (rs1 and rs2).

Test Plan:
- MUL: rs1 = 7, rs2 = -3, selects 0 -> stall high for 33 cycles, result_valid at cycle 34, result = 0xFFFFFFEB.
- MULHU with forwarding: ForwardRS1Src = 1, mem_fwd_data = 0xFFFFFFFF, rs2 = 0xFFFFFFFF -> result = 0xFFFFFFFE. rs1_data ignored. Changing mem_fwd_data after acceptance has no effect.
- DIV/REM signed: -7 / 2 -> DIV = 0xFFFFFFFD (-3); REM = 0xFFFFFFFF (-1); selects 2 via wb_fwd_data.
- Corner cases:
  - DIVU x / 0 with x = 0x1234 -> result 0xFFFFFFFF in 2 cycles.
  - REM 0x80000000 / -1 -> result 0 in 2 cycles.
- Flush at CALC cycle 10 -> stall low the same cycle, no result_valid, next request accepted normally. rst asserted mid-CALC -> all outputs 0 next cycle.
- Back-to-back DIVU then MULHSU (0xFFFFFFFF x 2) -> the second starts one cycle after DONE -> result 0xFFFFFFFF. With MULDIV_FAST_MUL_EN, the MULHSU result_valid arrives 2 cycles after acceptance.
